// File: rtl/latency_pipe_scheduler_pkg.sv
// Shared definitions for the latency pipe scheduler: default parameters,
// requester-id width helper and the response FIFO entry layout.
package latency_pipe_scheduler_pkg;

   localparam int DEFAULT_WIDTH      = 32;
   localparam int DEFAULT_LATENCY    = 4;
   localparam int DEFAULT_NUM_REQ    = 4;
   localparam int DEFAULT_FIFO_DEPTH = 8;

   // Bits needed to name one requester (never less than one bit).
   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   localparam int DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

   // Response FIFO entry at the default configuration: owning requester + result.
   // The top mirrors this layout with its own parameter-sized widths.
   typedef struct packed {
      logic [DEFAULT_ID_W-1:0]  id;
      logic [DEFAULT_WIDTH-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/latency_pipe_scheduler_if.sv
// Bundles the requester, shared-unit and response signals of the scheduler.
// slave = scheduler side, master = requesters plus the fixed-latency unit.
interface latency_pipe_scheduler_if #(
   parameter int WIDTH   = latency_pipe_scheduler_pkg::DEFAULT_WIDTH,
   parameter int NUM_REQ = latency_pipe_scheduler_pkg::DEFAULT_NUM_REQ
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_in1;
   logic [NUM_REQ*WIDTH-1:0] req_in2;
   logic                     unit_valid;
   logic [WIDTH-1:0]         unit_in1;
   logic [WIDTH-1:0]         unit_in2;
   logic [WIDTH-1:0]         unit_out;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]         rsp_data;

   modport slave (
      input  req_valid, req_in1, req_in2, unit_out, rsp_ready,
      output req_ready, unit_valid, unit_in1, unit_in2, rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_in1, req_in2, unit_out, rsp_ready,
      input  req_ready, unit_valid, unit_in1, unit_in2, rsp_valid, rsp_data
   );
endinterface

// File: rtl/latency_pipe_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the priority pointer; the pointer moves past the winner when i_advance is set.
module rr_arbiter
   import latency_pipe_scheduler_pkg::*;
#(
   parameter  int NUM_REQ = DEFAULT_NUM_REQ,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic               i_clock,
   input  logic               i_reset,      // active-low, synchronous
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_grant_id
);

   logic [ID_W-1:0] r_ptr;
   logic            w_found;

   // Scan requesters in circular order from the pointer; first valid one wins.
   always_comb begin
      o_grant    = '0;
      o_grant_id = '0;
      w_found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_found                                = 1'b1;
            o_grant[(int'(r_ptr) + k) % NUM_REQ]   = 1'b1;
            o_grant_id                             = ID_W'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Priority pointer: winner+1 (mod NUM_REQ) after each accept, 0 on reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= (o_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/latency_pipe_scheduler.sv
// Shares one fixed-latency unit among NUM_REQ requesters. Accepted requests are
// issued from a register, their requester id rides a LATENCY-deep tag pipe, and
// results land in an in-order response FIFO. Credit counts everything in flight
// so the FIFO can never overflow.
// Optional: define LATENCY_PIPE_SCHEDULER_STATS_EN for accept/stall counters.
module latency_pipe_scheduler
   import latency_pipe_scheduler_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int LATENCY    = DEFAULT_LATENCY,
   parameter int NUM_REQ    = DEFAULT_NUM_REQ,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic        i_clock,
   input  logic        i_reset,            // active-low, synchronous
`ifdef LATENCY_PIPE_SCHEDULER_STATS_EN
   output logic [31:0] o_stat_issued,
   output logic [31:0] o_stat_stall,
`endif
   latency_pipe_scheduler_if.slave bus
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
   } entry_t;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_grant_id;
   logic               w_credit;
   logic               w_accept;
   logic [CNT_W-1:0]   w_inflight;

   logic               r_iss_valid;
   logic [ID_W-1:0]    r_iss_id;
   logic [WIDTH-1:0]   r_iss_in1;
   logic [WIDTH-1:0]   r_iss_in2;

   logic [LATENCY-1:0] r_tag_v;
   logic [ID_W-1:0]    r_tag_id [LATENCY];

   entry_t             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   entry_t             w_head;
   logic               w_nonempty;
   logic               w_wr;
   logic               w_pop;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_req      (bus.req_valid),
      .i_advance  (w_accept),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id)
   );

   // Count issued-but-unwritten results sitting in the tag pipe.
   always_comb begin
      w_inflight = '0;
      for (int k = 0; k < LATENCY; k++) begin
         w_inflight = w_inflight + CNT_W'(r_tag_v[k]);
      end
   end

   // Credit uses only registered terms, so a pop frees a slot one cycle later.
   assign w_credit = (CNT_W'(r_count) + CNT_W'(r_iss_valid) + w_inflight) < CNT_W'(FIFO_DEPTH);
   assign w_accept = i_reset && w_credit && (|bus.req_valid);
   assign bus.req_ready = w_accept ? w_grant : '0;

   // Issue register: winner's operands go to the unit one cycle after accept.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_iss_valid <= 1'b0;
         r_iss_id    <= '0;
         r_iss_in1   <= '0;
         r_iss_in2   <= '0;
      end else begin
         r_iss_valid <= w_accept;
         r_iss_id    <= w_accept ? w_grant_id : '0;
         r_iss_in1   <= w_accept ? bus.req_in1[int'(w_grant_id) * WIDTH +: WIDTH] : '0;
         r_iss_in2   <= w_accept ? bus.req_in2[int'(w_grant_id) * WIDTH +: WIDTH] : '0;
      end
   end

   assign bus.unit_valid = r_iss_valid;
   assign bus.unit_in1   = r_iss_in1;
   assign bus.unit_in2   = r_iss_in2;

   // Tag pipe head: follows the issue register so the last stage lines up with unit_out.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_tag_v[0]  <= 1'b0;
         r_tag_id[0] <= '0;
      end else begin
         r_tag_v[0]  <= r_iss_valid;
         r_tag_id[0] <= r_iss_id;
      end
   end

   generate
      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
         // Tag pipe stage gi: plain shift of the previous stage.
         always_ff @(posedge i_clock) begin
            if (!i_reset) begin
               r_tag_v[gi]  <= 1'b0;
               r_tag_id[gi] <= '0;
            end else begin
               r_tag_v[gi]  <= r_tag_v[gi-1];
               r_tag_id[gi] <= r_tag_id[gi-1];
            end
         end
      end
   endgenerate

   assign w_wr       = r_tag_v[LATENCY-1];
   assign w_nonempty = (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_pop      = w_nonempty && bus.rsp_ready[w_head.id];

   // FIFO storage: capture the unit result with its tag as the tag exits.
   always_ff @(posedge i_clock) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= '{id: r_tag_id[LATENCY-1], data: bus.unit_out};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.rsp_valid = (i_reset && w_nonempty) ? (NUM_REQ'(1) << w_head.id) : '0;
   assign bus.rsp_data  = (i_reset && w_nonempty) ? w_head.data : '0;

`ifdef LATENCY_PIPE_SCHEDULER_STATS_EN
   logic        w_stall;
   logic [31:0] r_stat_issued;
   logic [31:0] r_stat_stall;

   assign w_stall = i_reset && (|bus.req_valid) && !w_credit;

   // Saturating counters of accepts and credit-starved cycles.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_stat_issued <= '0;
         r_stat_stall  <= '0;
      end else begin
         if (w_accept && !(&r_stat_issued)) r_stat_issued <= r_stat_issued + 1'b1;
         if (w_stall  && !(&r_stat_stall))  r_stat_stall  <= r_stat_stall + 1'b1;
      end
   end

   assign o_stat_issued = r_stat_issued;
   assign o_stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_latency_pipe_scheduler.sv
// Randomized scoreboard bench for latency_pipe_scheduler (WIDTH=32, LATENCY=4,
// NUM_REQ=4, FIFO_DEPTH=8, unit = in1+in2). Honours LATENCY_PIPE_SCHEDULER_STATS_EN.
module tb_latency_pipe_scheduler;

   localparam int W = 32;
   localparam int L = 4;
   localparam int N = 4;
   localparam int D = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   latency_pipe_scheduler_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

`ifdef LATENCY_PIPE_SCHEDULER_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_stall;
`endif

   latency_pipe_scheduler #(.WIDTH(W), .LATENCY(L), .NUM_REQ(N), .FIFO_DEPTH(D)) dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
`ifdef LATENCY_PIPE_SCHEDULER_STATS_EN
      .o_stat_issued (stat_issued),
      .o_stat_stall  (stat_stall),
`endif
      .bus           (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference state: what the specification says must be in the system.
   typedef struct {
      int           id;
      logic [W-1:0] data;
      int           acc;
   } exp_t;

   exp_t         exp_q[$];
   int           n_acc = 0;
   int           n_pop = 0;
   int           ptr   = 0;
   bit           prev_acc = 1'b0;
   logic [W-1:0] prev_in1, prev_in2;
   int           exp_issued = 0;
   int           exp_stall  = 0;

   // Unit model: sum of operands appears exactly L cycles after unit_valid;
   // idle cycles return random junk.
   logic [W-1:0] uhist[$];
   initial begin
      bus.unit_out = '0;
      for (int k = 0; k < L; k++) uhist.push_back(32'hBAD0_0000 + W'(k));
   end
   always @(negedge clk) begin
      uhist.push_back(bus.unit_valid ? bus.unit_in1 + bus.unit_in2 : W'($urandom()));
      bus.unit_out = uhist.pop_front();
   end

   // Request-side monitor: predicts grant, credit and issue; pushes expected responses.
   always @(negedge clk) begin
      bit           credit;
      int           win;
      int           idx;
      logic [N-1:0] exp_ready;
      if (!rst_n) begin
         check("req_ready_rst", 64'(bus.req_ready), 64'(0));
         check("rsp_valid_rst", 64'(bus.rsp_valid), 64'(0));
         ptr        = 0;
         n_acc      = 0;
         prev_acc   = 1'b0;
         exp_issued = 0;
         exp_stall  = 0;
      end else begin
         check("unit_valid", 64'(bus.unit_valid), 64'(prev_acc));
         if (prev_acc) begin
            check("unit_in1", 64'(bus.unit_in1), 64'(prev_in1));
            check("unit_in2", 64'(bus.unit_in2), 64'(prev_in2));
         end
         credit    = (n_acc - n_pop) < D;
         win       = -1;
         exp_ready = '0;
         if (credit) begin
            for (int k = 0; k < N; k++) begin
               idx = (ptr + k) % N;
               if (win < 0 && bus.req_valid[idx]) win = idx;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
         check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
`ifdef LATENCY_PIPE_SCHEDULER_STATS_EN
         check("stat_issued", 64'(stat_issued), 64'(exp_issued));
         check("stat_stall", 64'(stat_stall), 64'(exp_stall));
`endif
         if (!credit && (|bus.req_valid)) exp_stall++;
         if (win >= 0) begin
            prev_in1 = bus.req_in1[win*W +: W];
            prev_in2 = bus.req_in2[win*W +: W];
            exp_q.push_back('{id: win, data: prev_in1 + prev_in2, acc: cyc});
            n_acc++;
            exp_issued++;
            ptr      = (win + 1) % N;
            prev_acc = 1'b1;
         end else begin
            prev_acc = 1'b0;
         end
      end
   end

   // Response-side monitor: head becomes visible L+2 cycles after its accept.
   always @(negedge clk) begin
      logic [N-1:0] exp_valid;
      if (!rst_n) begin
         exp_q.delete();
         n_pop <= 0;
      end else begin
         exp_valid = '0;
         if (exp_q.size() > 0 && cyc >= exp_q[0].acc + L + 2) exp_valid[exp_q[0].id] = 1'b1;
         check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
         if (exp_valid != '0) begin
            check("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].data));
            if (bus.rsp_ready[exp_q[0].id]) begin
               $display("rsp cycle=%0d id=%0d data=%08h accepted_at=%0d",
                        cyc, exp_q[0].id, exp_q[0].data, exp_q[0].acc);
               void'(exp_q.pop_front());
               n_pop <= n_pop + 1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      for (int k = 0; k < N; k++) begin
         bus.req_in1[k*W +: W] = W'($urandom());
         bus.req_in2[k*W +: W] = W'($urandom());
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_unit_valid"}, 64'(bus.unit_valid), 64'(0));
      check({tag, "_unit_in1"},   64'(bus.unit_in1),   64'(0));
      check({tag, "_unit_in2"},   64'(bus.unit_in2),   64'(0));
      check({tag, "_rsp_valid"},  64'(bus.rsp_valid),  64'(0));
      check({tag, "_rsp_data"},   64'(bus.rsp_data),   64'(0));
      check({tag, "_req_ready"},  64'(bus.req_ready),  64'(0));
`ifdef LATENCY_PIPE_SCHEDULER_STATS_EN
      check({tag, "_stat_issued"}, 64'(stat_issued), 64'(0));
      check({tag, "_stat_stall"},  64'(stat_stall),  64'(0));
`endif
   endtask

   initial begin
      int guard;
      bus.req_valid = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      bus.rsp_ready = '0;
      rst_n         = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      rst_n         = 1'b1;
      bus.rsp_ready = 4'hF;
      repeat (6) step();

      // Single request from requester 2: 1 + 2.
      bus.req_valid        = 4'b0100;
      bus.req_in1[2*W +: W] = 32'h1;
      bus.req_in2[2*W +: W] = 32'h2;
      step();
      bus.req_valid = '0;
      repeat (10) step();

      // All four requesters continuously, responses always accepted.
      bus.req_valid = 4'hF;
      repeat (40) begin rand_ops(); step(); end
      bus.req_valid = '0;
      repeat (10) step();

      // Backpressure: one requester streams into a blocked response path.
      bus.rsp_ready = '0;
      bus.req_valid = 4'b0010;
      repeat (20) begin rand_ops(); step(); end
      bus.rsp_ready = 4'hF;
      repeat (12) begin rand_ops(); step(); end
      bus.req_valid = '0;
      repeat (12) step();

      // Head-of-line: head owned by requester 1, only requester 0 ready.
      bus.rsp_ready = '0;
      bus.req_valid = 4'b0010;
      rand_ops();
      step();
      bus.req_valid = 4'b0001;
      repeat (2) begin rand_ops(); step(); end
      bus.req_valid = '0;
      repeat (8) step();
      bus.rsp_ready = 4'b0001;
      repeat (8) step();
      bus.rsp_ready = 4'b0010;
      repeat (4) step();
      bus.rsp_ready = 4'hF;
      repeat (6) step();

      // Random traffic with random response backpressure.
      repeat (1500) begin
         bus.req_valid = N'($urandom());
         bus.rsp_ready = ($urandom_range(0, 3) == 0) ? N'($urandom()) : 4'hF;
         rand_ops();
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 4'hF;
      repeat (15) step();

      // Reset with three results in flight; nothing may come back afterwards.
      bus.req_valid = 4'b1000;
      repeat (3) begin rand_ops(); step(); end
      bus.req_valid = '0;
      step();
      rst_n = 1'b0;
      step();
      check_all_zero("midreset");
      rst_n = 1'b1;
      repeat (10) step();

      // Short random burst, then drain with a bounded wait.
      repeat (200) begin
         bus.req_valid = N'($urandom());
         bus.rsp_ready = N'($urandom());
         rand_ops();
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 4'hF;
      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         step();
         guard++;
      end
      check("drain_left", 64'(exp_q.size()), 64'(0));
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
